shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for variable-amount shifts (SLL/SRL/SRA/ROTR) in the MIPS-32 execute stage.
//  Accepts one shift request, iterates a combinational stage shifting by STEP or 1 bit per cycle,
//  and signals completion with a one-cycle done pulse. The pipeline stalls on busy; a flush aborts it via kill.
// PARAMETERS
//  SIZE     32  datapath width in bits
//  STEP     4   large per-cycle shift amount; power of two, 2..SIZE/2
//  SHAMT_W  5   shift-amount width, $clog2(SIZE)
// PORTS
//  clk      in   1        rising-edge clock; the block's only clock
//  rst      in   1        synchronous, active-high reset
//  start    in   1        request strobe; sampled only in IDLE or DONE
//  kill     in   1        abort (pipeline flush); has priority over start
//  op       in   2        00 SLL, 01 SRL, 10 SRA, 11 ROTR (right rotate)
//  data_in  in   SIZE     operand, captured on accepted start
//  shamt    in   SHAMT_W  shift amount, captured on accepted start
//  busy     out  1        high in SHIFT state
//  done     out  1        one-cycle completion pulse (DONE state)
//  result   out  SIZE     accumulator; valid while done=1, stable until next accepted start
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, busy=0, done=0, result=0, count=0, latched op=00; overrides all inputs.
//  States: IDLE, SHIFT, DONE.
//  - IDLE/DONE with start=1 and kill=0: acc<=data_in, cnt<=shamt, op latched.
//    Next state is DONE if shamt==0, otherwise SHIFT.
//  - IDLE/DONE with start=0: next state is IDLE. done is therefore exactly one cycle wide;
//    back-to-back starts are accepted while in DONE.
//  - SHIFT:
//    - cnt>=STEP: acc <= stage(acc, op, STEP), cnt -= STEP.
//    - otherwise: acc <= stage(acc, op, 1), cnt -= 1.
//    - Go to DONE when the updated cnt is 0; stay in SHIFT otherwise.
//  - start while in SHIFT is ignored; no queuing. The requester must hold or re-issue it.
//  - kill=1 in any state: next state is IDLE, and no done is produced for the aborted operation.
//    acc keeps its partial value. kill together with start: the start is dropped.
//  Latency (start edge to done high): 1 + floor(shamt/STEP) + (shamt mod STEP) cycles.
//    shamt=0 -> 1; shamt=31, STEP=4 -> 11.
//  Arithmetic:
//    - SLL fills zeros on the right.
//    - SRL fills zeros on the left.
//    - SRA replicates acc[SIZE-1] each step.
//    - ROTR wraps the low bits to the top.
//    - All operations are SIZE-bit with no carry-out. cnt never underflows: step is min(STEP, cnt).
//  busy=1 iff state==SHIFT; done=1 iff state==DONE; the two are never high together.
// STRUCTURE
//  - Shared package/header shift_pkg:
//    - op encodings OP_SLL/OP_SRL/OP_SRA/OP_ROTR.
//    - state encodings ST_IDLE/ST_SHIFT/ST_DONE.
//  - One sub-module, shift_stage: combinational, parameters SIZE and STEP.
//    - inputs a, op, big (1 = shift by STEP, 0 = shift by 1); output y.
//    - contains no state.
//  - The top level holds the FSM, the cnt and acc registers, and the op latch.
// TESTING
//  1. SLL: data_in=0x0000_0001, shamt=31 -> done at cycle 11 after start, result=0x8000_0000.
//     busy=1 for cycles 1..10.
//  2. SRA: data_in=0x8000_00F0, shamt=5 -> done at cycle 3, result=0xFC00_0007.
//     SRL with the same inputs gives result=0x0400_0007.
//  3. ROTR: data_in=0x1234_5678, shamt=8 -> done at cycle 3, result=0x7812_3456.
//     SLL with shamt=0 -> done at cycle 1, result=data_in.
//  4. Back-to-back and ignored start:
//     - start asserted in the DONE cycle is accepted, and a second done follows.
//     - start pulsed during SHIFT is ignored: exactly one done, and result is unchanged by the stray start.
//  5. kill mid-SHIFT (shamt=20, kill at cycle 2) -> IDLE next cycle, no done pulse.
//     kill+start in the same cycle -> stays IDLE.
//  6. rst asserted mid-SHIFT -> next cycle busy=0, done=0, result=0.
//     Then a random op/shamt run is checked against a reference model (1000 vectors).

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer slice.
//   op_e    : shift operation encodings driven on the request bus
//   state_e : sequencer FSM states (IDLE, SHIFT, DONE)
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bus between the execute-stage requester and the shift sequencer.
//   start, kill, op, data_in, shamt : request side, driven by the requester (master)
//   busy, done, result              : status side, driven by the sequencer (slave)
interface shift_sequencer_if
    import shift_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic               kill;
    op_e                op;
    logic [SIZE-1:0]    data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [SIZE-1:0]    result;

    modport master (
        output start, kill, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, data_in, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/shift_stage.sv
// One combinational shift step of the sequencer.
//   a   : value to shift
//   op  : SLL / SRL / SRA / ROTR
//   big : 1 shifts by STEP bits, 0 shifts by a single bit
//   y   : shifted value, SIZE bits, no carry-out
module shift_stage
    import shift_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int STEP = 4
) (
    input  logic [SIZE-1:0] a,
    input  op_e             op,
    input  logic            big,
    output logic [SIZE-1:0] y
);

    logic signed [SIZE-1:0] a_s;

    assign a_s = a;

    // Two fixed shift amounts only, so each operation is a pair of constant
    // shifts selected by big rather than a general barrel shifter.
    always_comb begin
        y = a;
        case (op)
            OP_SLL:  y = big ? (a << STEP) : (a << 1);
            OP_SRL:  y = big ? (a >> STEP) : (a >> 1);
            OP_SRA:  y = big ? (a_s >>> STEP) : (a_s >>> 1);
            OP_ROTR: y = big ? {a[STEP-1:0], a[SIZE-1:STEP]} : {a[0], a[SIZE-1:1]};
            default: y = a;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shift controller for the execute stage.
// Accepts one request, steps the accumulator by STEP or 1 bit per cycle and
// pulses done for one cycle when finished. A kill aborts without a done.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : request/status bus (slave side), see shift_sequencer_if
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    shift_sequencer_if.slave    bus
);

    localparam logic [SHAMT_W-1:0] STEP_CNT = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] ONE_CNT  = SHAMT_W'(1);

    state_e             state;
    op_e                op_q;
    logic [SIZE-1:0]    acc;
    logic [SHAMT_W-1:0] cnt;
    logic               busy_q;
    logic               done_q;

    logic               big;
    logic [SHAMT_W-1:0] cnt_next;
    logic [SIZE-1:0]    stage_y;

    // Take the large step only while it cannot overshoot, so cnt never underflows.
    assign big      = (cnt >= STEP_CNT);
    assign cnt_next = cnt - (big ? STEP_CNT : ONE_CNT);

    shift_stage #(
        .SIZE (SIZE),
        .STEP (STEP)
    ) u_stage (
        .a   (acc),
        .op  (op_q),
        .big (big),
        .y   (stage_y)
    );

    // FSM plus datapath registers. busy/done are registered alongside the
    // state so they are exact decodes of SHIFT/DONE with no combinational path.
    // kill outranks everything except reset and leaves acc at its partial value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_SLL;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.kill) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        acc  <= bus.data_in;
                        cnt  <= bus.shamt;
                        op_q <= bus.op;
                        if (bus.shamt == '0) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_SHIFT;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    acc <= stage_y;
                    cnt <= cnt_next;
                    if (cnt_next == '0) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios followed by a
// randomized run compared against an arithmetic reference model.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    shift_sequencer_if #(.SIZE(32), .SHAMT_W(5)) bus ();

    shift_sequencer #(
        .SIZE    (32),
        .STEP    (4),
        .SHAMT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the operation's definition.
    function automatic logic [31:0] model_result(input op_e o, input logic [31:0] d,
                                                 input logic [4:0] s);
        logic signed [31:0] ds;
        ds = d;
        case (o)
            OP_SLL:  return d << s;
            OP_SRL:  return d >> s;
            OP_SRA:  return ds >>> s;
            default: return (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
        endcase
    endfunction

    // Cycles from the accepting edge to done: one for acceptance, then big
    // steps of 4 followed by single-bit steps.
    function automatic int model_latency(input logic [4:0] s);
        return 1 + (int'(s) / 4) + (int'(s) % 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; data_in is scrambled afterwards so a design that
    // fails to capture it shows up in the result.
    task automatic applyStimulus(input op_e o, input logic [31:0] d, input logic [4:0] s);
        bus.op      = o;
        bus.data_in = d;
        bus.shamt   = s;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.data_in = ~d;
        bus.shamt   = 5'd31;
        bus.op      = OP_ROTR;
    endtask

    // Issues a request and follows it to done, checking busy on every cycle
    // in between, the latency and the result. Returns in the DONE cycle.
    task automatic runOp(input string tag, input op_e o, input logic [31:0] d,
                         input logic [4:0] s);
        int lat;
        bit seen;
        applyStimulus(o, d, s);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 40) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
                tick();
                lat++;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(model_latency(s)));
        checkOutput({tag, "_result"}, bus.result, model_result(o, d, s));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        bus.op      = OP_SLL;
        bus.data_in = '0;
        bus.shamt   = '0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        tick();

        $display("[TB] directed operations");
        runOp("sll31", OP_SLL, 32'h0000_0001, 5'd31);
        checkOutput("sll31_value", bus.result, 32'h8000_0000);
        tick();
        checkOutput("sll31_done_width", 32'(bus.done), 32'd0);
        runOp("sra5", OP_SRA, 32'h8000_00F0, 5'd5);
        checkOutput("sra5_value", bus.result, 32'hFC00_0007);
        // Start issued in the DONE cycle: back-to-back acceptance.
        runOp("srl5_b2b", OP_SRL, 32'h8000_00F0, 5'd5);
        checkOutput("srl5_value", bus.result, 32'h0400_0007);
        runOp("rotr8", OP_ROTR, 32'h1234_5678, 5'd8);
        checkOutput("rotr8_value", bus.result, 32'h7812_3456);
        tick();
        runOp("sll0", OP_SLL, 32'hDEAD_BEEF, 5'd0);
        checkOutput("sll0_value", bus.result, 32'hDEAD_BEEF);
        tick();

        $display("[TB] stray start during SHIFT");
        applyStimulus(OP_SLL, 32'h0000_0001, 5'd31);
        tick();
        bus.op      = OP_ROTR;
        bus.data_in = 32'h0000_FFFF;
        bus.shamt   = 5'd0;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        lat   = 3;
        dones = 0;
        while (bus.done !== 1'b1 && lat <= 40) begin
            tick();
            lat++;
        end
        checkOutput("stray_latency", 32'(lat), 32'd11);
        checkOutput("stray_result", bus.result, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checkOutput("stray_single_done", 32'(dones), 32'd0);
        checkOutput("stray_result_held", bus.result, 32'h8000_0000);

        $display("[TB] kill handling");
        applyStimulus(OP_SLL, 32'h0000_0001, 5'd20);
        tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        checkOutput("kill_busy", 32'(bus.busy), 32'd0);
        checkOutput("kill_done", 32'(bus.done), 32'd0);
        checkOutput("kill_partial", bus.result, 32'h0000_0010);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checkOutput("kill_no_done", 32'(dones), 32'd0);
        bus.op      = OP_SLL;
        bus.data_in = 32'h0000_0055;
        bus.shamt   = 5'd0;
        bus.start   = 1'b1;
        bus.kill    = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        checkOutput("killstart_busy", 32'(bus.busy), 32'd0);
        checkOutput("killstart_done", 32'(bus.done), 32'd0);
        checkOutput("killstart_result", bus.result, 32'h0000_0010);

        $display("[TB] reset during SHIFT");
        applyStimulus(OP_SLL, 32'h0000_1234, 5'd20);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        tick();
        checkOutput("rst_stays_idle", 32'({bus.busy, bus.done}), 32'd0);

        $display("[TB] randomized run");
        for (int n = 0; n < 1000; n++) begin
            runOp("rand", op_e'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) begin
                tick();
                checkOutput("rand_idle_done", 32'(bus.done), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
